// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames (8E1 when UART_TX_PARITY_EN is defined) with a
// shift register plus a one-byte holding register for back-to-back frames.
module uart_tx #(
    parameter int unsigned p_CLKs_PB = 217
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam logic [15:0] c_LAST_CNT = 16'(p_CLKs_PB - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP_BIT  = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        STOP_BIT  = 3'd4
    } state_t;
`endif

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [2:0]  idx_r, idx_s;
    logic [7:0]  shift_r, shift_s;
    logic [7:0]  hold_r, hold_s;
    logic        hold_full_r, hold_full_s;
    logic        serial_r, serial_s;
    logic        active_r, active_s;
    logic        done_r, done_s;
    logic        ready_r, ready_s;
    logic        accept_s;
    logic        last_s;
    logic        load_s;
`ifdef UART_TX_PARITY_EN
    logic        parity_r, parity_s;
`endif

    // Next-state, datapath and next-output computation
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        shift_s     = shift_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
`ifdef UART_TX_PARITY_EN
        parity_s    = parity_r;
`endif
        accept_s    = i_Tx_DV & ready_r;
        last_s      = (cnt_r == c_LAST_CNT);
        load_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    load_s  = 1'b1;
                    state_s = START_BIT;
                    cnt_s   = 16'd0;
                end else begin
                    cnt_s   = 16'd0;
                end
            end
            START_BIT: begin
                if (last_s) begin
                    state_s = DATA;
                    cnt_s   = 16'd0;
                    idx_s   = 3'd0;
                end else begin
                    cnt_s   = cnt_r + 16'd1;
                end
            end
            DATA: begin
                if (last_s) begin
                    cnt_s   = 16'd0;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP_BIT;
`endif
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last_s) begin
                    state_s = STOP_BIT;
                    cnt_s   = 16'd0;
                end else begin
                    cnt_s   = cnt_r + 16'd1;
                end
            end
`endif
            STOP_BIT: begin
                if (last_s) begin
                    cnt_s = 16'd0;
                    // A pending byte wins; otherwise a same-cycle accept goes straight in
                    if (hold_full_r) begin
                        shift_s     = hold_r;
`ifdef UART_TX_PARITY_EN
                        parity_s    = even_parity(hold_r);
`endif
                        hold_full_s = 1'b0;
                        state_s     = START_BIT;
                    end else if (accept_s) begin
                        load_s      = 1'b1;
                        state_s     = START_BIT;
                    end else begin
                        state_s     = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 16'd0;
            end
        endcase

        if (load_s) begin
            shift_s  = i_Tx_Byte;
`ifdef UART_TX_PARITY_EN
            parity_s = even_parity(i_Tx_Byte);
`endif
        end else if (accept_s) begin
            hold_s      = i_Tx_Byte;
            hold_full_s = 1'b1;
        end else begin
            hold_s = hold_r;
        end

        ready_s  = ~hold_full_s;
        active_s = (state_s != IDLE);
        done_s   = (state_s == STOP_BIT) && (cnt_s == c_LAST_CNT);
        case (state_s)
            IDLE:      serial_s = 1'b1;
            START_BIT: serial_s = 1'b0;
            DATA:      serial_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            PARITY:    serial_s = parity_s;
`endif
            STOP_BIT:  serial_s = 1'b1;
            default:   serial_s = 1'b1;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 16'd0;
            idx_r       <= 3'd0;
            shift_r     <= 8'd0;
            hold_r      <= 8'd0;
            hold_full_r <= 1'b0;
            serial_r    <= 1'b1;
            active_r    <= 1'b0;
            done_r      <= 1'b0;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            shift_r     <= shift_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            serial_r    <= serial_s;
            active_r    <= active_s;
            done_r      <= done_s;
            ready_r     <= ready_s;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the byte currently in the shifter, captured at load time
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_s;
        end
    end
`endif

    assign o_Tx_Ready  = ready_r;
    assign o_Tx_Serial = serial_r;
    assign o_Tx_Active = active_r;
    assign o_Tx_Done   = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model compared every
// cycle, plus hand-computed line values pinned at specific cycles.
module tb_uart_tx;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] c_A5_LIT = 11'b101_0100_1010;
    localparam logic [10:0] c_07_LIT = 11'b110_0000_1110;
`else
    localparam int NB = 10;
    localparam logic [10:0] c_A5_LIT = 11'b011_0100_1010;
    localparam logic [10:0] c_07_LIT = 11'b010_0000_1110;
`endif
    localparam int FL = NB * N;

    logic       i_Clk     = 1'b0;
    logic       i_Rst_n   = 1'b1;
    logic       i_Tx_DV   = 1'b0;
    logic [7:0] i_Tx_Byte = 8'h00;
    logic       o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    uart_tx #(.p_CLKs_PB(N)) dut (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Tx_DV    (i_Tx_DV),
        .i_Tx_Byte  (i_Tx_Byte),
        .o_Tx_Ready (o_Tx_Ready),
        .o_Tx_Serial(o_Tx_Serial),
        .o_Tx_Active(o_Tx_Active),
        .o_Tx_Done  (o_Tx_Done)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is NB bits of N cycles; position t within it
    bit         m_busy = 1'b0;
    bit         m_pend = 1'b0;
    bit         m_ready = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_pend_byte = 8'h00;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NB == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    always @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            m_busy  <= 1'b0;
            m_pend  <= 1'b0;
            m_ready <= 1'b0;
            m_t     <= 0;
        end else begin : model_step
            bit         acc, busy, pend;
            int         t;
            logic [7:0] cur, pb;
            acc  = i_Tx_DV && m_ready;
            busy = m_busy;
            pend = m_pend;
            t    = m_t;
            cur  = m_cur;
            pb   = m_pend_byte;
            if (busy) begin
                if (t == FL - 1) begin
                    t = 0;
                    if (pend) begin
                        cur  = pb;
                        pend = 1'b0;
                    end else if (acc) begin
                        cur = i_Tx_Byte;
                    end else begin
                        busy = 1'b0;
                    end
                end else begin
                    t++;
                    if (acc) begin
                        pb   = i_Tx_Byte;
                        pend = 1'b1;
                    end
                end
            end else if (acc) begin
                busy = 1'b1;
                t    = 0;
                cur  = i_Tx_Byte;
            end
            m_busy      <= busy;
            m_pend      <= pend;
            m_t         <= t;
            m_cur       <= cur;
            m_pend_byte <= pb;
            m_ready     <= !pend;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge i_Clk) begin
        if (chk_en) begin
            chk("model serial", o_Tx_Serial, m_busy ? frame_bit(m_cur, m_t / N) : 1'b1);
            chk("model active", o_Tx_Active, m_busy);
            chk("model done",   o_Tx_Done,   m_busy && (m_t == FL - 1));
            chk("model ready",  o_Tx_Ready,  m_ready);
        end
    end

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    // Sends one byte from idle and pins each bit start against a literal frame
    task automatic send_pin(input logic [7:0] b, input logic [10:0] lit, input string tag);
        i_Tx_Byte = b;
        i_Tx_DV   = 1'b1;
        step();
        i_Tx_DV   = 1'b0;
        i_Tx_Byte = ~b;
        for (int k = 1; k <= FL + 1; k++) begin
            if (k > 1) step();
            if (((k - 1) % N == 0) && (k <= FL)) chk({tag, " bit"}, o_Tx_Serial, lit[(k-1)/N]);
            if (k >= FL - 1) chk({tag, " done"}, o_Tx_Done, (k == FL));
            if (k == FL + 1) chk({tag, " active end"}, o_Tx_Active, 1'b0);
        end
    endtask

    initial begin
        #2 i_Rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst serial", o_Tx_Serial, 1'b1);
        chk("rst active", o_Tx_Active, 1'b0);
        chk("rst done",   o_Tx_Done,   1'b0);
        chk("rst ready",  o_Tx_Ready,  1'b0);
        repeat (2) @(posedge i_Clk);
        #3 i_Rst_n = 1'b1;
        chk("ready before edge", o_Tx_Ready, 1'b0);
        step();
        chk("ready after release", o_Tx_Ready, 1'b1);

        // Single byte, LSB first
        send_pin(8'hA5, c_A5_LIT, "A5");

        // Two bytes with DV held, third offered while holding register full
        i_Tx_Byte = 8'h3C;
        i_Tx_DV   = 1'b1;
        step();
        i_Tx_Byte = 8'hC3;
        step();
        chk("held ready low", o_Tx_Ready, 1'b0);
        i_Tx_Byte = 8'h55;
        for (int k = 3; k <= 2 * FL + 1; k++) begin
            step();
            if (k == 20) i_Tx_DV = 1'b0;
            if (k == FL) begin
                chk("b2b ready at end", o_Tx_Ready, 1'b0);
                chk("b2b done", o_Tx_Done, 1'b1);
            end
            if (k == FL + 1) begin
                chk("b2b start", o_Tx_Serial, 1'b0);
                chk("b2b active", o_Tx_Active, 1'b1);
                chk("b2b ready rise", o_Tx_Ready, 1'b1);
            end
            if (k == FL + 1 + N) chk("C3 bit0", o_Tx_Serial, 1'b1);
            if (k == FL + 1 + 3 * N) chk("C3 bit2", o_Tx_Serial, 1'b0);
            if (k == 2 * FL + 1) chk("third ignored", o_Tx_Active, 1'b0);
        end

        // Accept coincident with the last stop cycle
        i_Tx_Byte = 8'h81;
        i_Tx_DV   = 1'b1;
        step();
        i_Tx_DV = 1'b0;
        repeat (FL - 1) step();
        chk("coinc done", o_Tx_Done, 1'b1);
        i_Tx_Byte = 8'h42;
        i_Tx_DV   = 1'b1;
        step();
        i_Tx_DV = 1'b0;
        chk("coinc start", o_Tx_Serial, 1'b0);
        chk("coinc active", o_Tx_Active, 1'b1);
        repeat (FL + 2) step();
        chk("coinc idle", o_Tx_Active, 1'b0);

        // Reset during data bit 3 of 0xFF with a byte held
        i_Tx_Byte = 8'hFF;
        i_Tx_DV   = 1'b1;
        step();
        i_Tx_Byte = 8'h00;
        step();
        i_Tx_DV = 1'b0;
        repeat (16) step();
        #2 i_Rst_n = 1'b0;
        #1;
        chk("mid rst serial", o_Tx_Serial, 1'b1);
        chk("mid rst active", o_Tx_Active, 1'b0);
        chk("mid rst done",   o_Tx_Done,   1'b0);
        chk("mid rst ready",  o_Tx_Ready,  1'b0);
        @(posedge i_Clk);
        #2 i_Rst_n = 1'b1;
        chk("mid rel ready before", o_Tx_Ready, 1'b0);
        step();
        chk("mid rel ready", o_Tx_Ready, 1'b1);
        chk("mid rel serial", o_Tx_Serial, 1'b1);
        repeat (FL + 5) step();
        chk("no held frame", o_Tx_Active, 1'b0);

        // Second pinned frame (parity 1 when parity is enabled)
        send_pin(8'h07, c_07_LIT, "07");

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter p_CLKs_PB, default 217, the clock cycles per serial bit; legal range 2 to 65535.
REQ-002 SHALL provide port i_Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port i_Rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port i_Tx_DV, input, 1, the byte-valid strobe.
REQ-005 SHALL provide port i_Tx_Byte, input, 8, the byte to send; sampled only on accept.
REQ-006 SHALL provide port o_Tx_Ready, output, 1, high when a byte can be accepted.
REQ-007 SHALL provide port o_Tx_Serial, output, 1, the UART line, idle high.
REQ-008 SHALL provide port o_Tx_Active, output, 1, high while a frame is on the line.
REQ-009 SHALL provide port o_Tx_Done, output, 1, a one-cycle frame-complete pulse.

Function
REQ-010 Accept SHALL occur on a rising edge where i_Tx_DV=1 and o_Tx_Ready=1; i_Tx_DV with o_Tx_Ready=0 SHALL be ignored and the byte is not captured.
REQ-011 Storage SHALL be a shift register plus a one-byte holding register; o_Tx_Ready = holding register empty.
REQ-012 On accept with the shifter idle, the byte SHALL load directly into the shifter; o_Tx_Serial goes low, and o_Tx_Active goes high, on the cycle after the accept edge.
REQ-013 On accept with the shifter busy, the byte SHALL load into the holding register; o_Tx_Ready goes low on the next cycle.
REQ-014 Transmitter states SHALL be IDLE, START_BIT, DATA, PARITY (macro only), and STOP_BIT.
REQ-015 IDLE SHALL drive o_Tx_Serial=1; START_BIT drives 0; DATA drives bits 0..7 LSB first; STOP_BIT drives 1.
REQ-016 Every bit SHALL last exactly p_CLKs_PB cycles, using a bit-cycle counter and a 3-bit data index; a frame is 10*p_CLKs_PB cycles (11* with parity).
REQ-017 o_Tx_Done SHALL be 1 for exactly one cycle, the last cycle of STOP_BIT.
REQ-018 At the end of STOP_BIT with the holding register full, the byte SHALL transfer to the shifter, START_BIT SHALL begin on the next cycle (no idle gap), o_Tx_Active SHALL stay 1, and o_Tx_Ready SHALL rise on that same next cycle.
REQ-019 When an accept coincides with the last STOP_BIT cycle and the holding register is empty, the byte SHALL load directly into the shifter and be sent back-to-back per REQ-018.
REQ-020 At the end of STOP_BIT with no pending byte, the state SHALL return to IDLE and o_Tx_Active SHALL fall on the next cycle.
REQ-021 i_Tx_Byte changes after an accept SHALL NOT affect the frame in flight or the held byte.

Reset
REQ-022 Asserting i_Rst_n=0 SHALL immediately force o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=0, state IDLE, and clear all counters and both registers.
REQ-023 o_Tx_Ready SHALL go to 1 on the first rising edge after i_Rst_n deasserts.
REQ-024 Reset mid-frame SHALL abort the frame and discard any held byte; the line stays high and no o_Tx_Done pulse is generated.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA for p_CLKs_PB cycles and drive the even-parity bit (XOR of the 8 data bits); the frame is 11 bits.
REQ-026 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP_BIT.

Verification (p_CLKs_PB=4)
REQ-027 Single byte 0xA5 accepted at cycle 0 -> line low cycles 1-4, then 1,0,1,0,0,1,0,1 for 4 cycles each, high cycles 37-40; o_Tx_Done=1 at cycle 40 only.
REQ-028 0x3C then 0xC3 sent with i_Tx_DV held -> second byte held; o_Tx_Ready low until the transfer; start bit of 0xC3 at cycle 41 with o_Tx_Active continuously 1.
REQ-029 Third byte offered while the holding register is full -> ignored; only two frames appear on the line.
REQ-030 i_Rst_n pulsed low during bit 3 of 0xFF -> o_Tx_Serial=1 immediately, no o_Tx_Done, o_Tx_Ready=1 one edge after release.
REQ-031 UART_TX_PARITY_EN defined, bytes 0xA5 and 0x07 -> parity bit 0 and 1 respectively; o_Tx_Done at cycle 44.
REQ-032 Accept coincident with the last STOP_BIT cycle (REQ-019) -> next start bit on the following cycle, no idle gap.
